// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32I pipeline opcodes and scoreboard entry type
//
// Purpose : opcode constants and the scoreboard entry layout used by the
//           hazard controller and its decoder.
// Ports   : none (package).
package rv_pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rd: 5'd0};

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - RV32I opcode to register-usage decoder
//
// Purpose : classifies an opcode by which register fields it reads/writes.
// Ports   : i_opcode     [6:0] instruction bits [6:0]
//           o_uses_rs1         instruction reads rs1
//           o_uses_rs2         instruction reads rs2
//           o_writes_rd        instruction writes rd
module hazard_decode
    import rv_pipe_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_writes_rd
);

    always_comb begin
        o_uses_rs1  = 1'b0;
        o_uses_rs2  = 1'b0;
        o_writes_rd = 1'b0;
        case (i_opcode)
            OP_ALU: begin
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_ALUI, OP_LOAD, OP_JALR: begin
                o_uses_rs1  = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                o_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall / control flush controller for a 5-stage pipe
//
// Purpose : tracks destinations of instructions in EX/MEM/WB, stalls ID on a
//           read-after-write hazard, flushes on a taken branch, freezes on hold,
//           and counts stall and flush cycles.
// Ports   : i_clk            clock
//           i_reset          asynchronous active-low reset
//           i_id_instr [31:0] instruction in IF/ID
//           i_id_vld         IF/ID holds a real instruction
//           i_ex_pc_sel      branch/jump taken in EX
//           i_hold           global freeze
//           o_pc_en          PC load enable
//           o_ifid_en        IF/ID load enable
//           o_ifid_flush     IF/ID loads a bubble
//           o_idex_flush     ID/EX loads a bubble
//           o_stall_cnt [31:0] hazard-stall cycles (saturating)
//           o_flush_cnt [31:0] control-flush cycles (saturating)
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_id_instr,
    input  logic        i_id_vld,
    input  logic        i_ex_pc_sel,
    input  logic        i_hold,
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    // Without a write-first register file the WB producer is still a hazard.
    localparam logic WB_HAZ = (WB_BYPASS == 0);

    sb_entry_t   r_ex;
    sb_entry_t   r_mem;
    sb_entry_t   r_wb;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_writes_rd;
    logic        w_match_rs1;
    logic        w_match_rs2;
    logic        w_hazard;
    logic        w_flush;
    logic        w_stall;
    logic        w_normal;
    sb_entry_t   w_ex_next;
    logic        w_unused_bits;

    assign w_rs1 = i_id_instr[19:15];
    assign w_rs2 = i_id_instr[24:20];
    assign w_rd  = i_id_instr[11:7];
    assign w_unused_bits = ^{i_id_instr[31:25], i_id_instr[14:12]};

    hazard_decode u_decode (
        .i_opcode    (i_id_instr[6:0]),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd)
    );

    function automatic logic sb_match(input sb_entry_t ex, input sb_entry_t mem,
                                      input sb_entry_t wb, input logic [4:0] r);
        return (r != 5'd0) &&
               ((ex.vld  && ex.rd  == r) ||
                (mem.vld && mem.rd == r) ||
                (WB_HAZ && wb.vld && wb.rd == r));
    endfunction

    assign w_match_rs1 = sb_match(r_ex, r_mem, r_wb, w_rs1);
    assign w_match_rs2 = sb_match(r_ex, r_mem, r_wb, w_rs2);
    assign w_hazard    = i_id_vld & ((w_uses_rs1 & w_match_rs1) |
                                     (w_uses_rs2 & w_match_rs2));

    // Priority: hold > flush > stall > normal.
    assign w_flush  = ~i_hold & i_ex_pc_sel;
    assign w_stall  = ~i_hold & ~i_ex_pc_sel & w_hazard;
    assign w_normal = ~i_hold & ~i_ex_pc_sel & ~w_hazard;

    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        if (w_flush) begin
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_stall) begin
            o_idex_flush = 1'b1;
        end else if (w_normal) begin
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
        end
    end

    always_comb begin
        w_ex_next = SB_EMPTY;
        if (w_normal) begin
            w_ex_next.vld = i_id_vld & w_writes_rd & (w_rd != 5'd0);
            w_ex_next.rd  = w_rd;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ex        <= SB_EMPTY;
            r_mem       <= SB_EMPTY;
            r_wb        <= SB_EMPTY;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (!i_hold) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_next;
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush && r_flush_cnt != 32'hFFFF_FFFF) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (WB_BYPASS=1 and 0 lanes)
module tb_hazard_ctrl;
    import rv_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] id_instr [2];
    logic        id_vld [2];
    logic        ex_pc_sel [2];
    logic        hold [2];
    logic        pc_en [2];
    logic        ifid_en [2];
    logic        ifid_flush [2];
    logic        idex_flush [2];
    logic [31:0] stall_cnt [2];
    logic [31:0] flush_cnt [2];

    hazard_ctrl #(.WB_BYPASS(1)) dut_bp (
        .i_clk(clk), .i_reset(rst_n), .i_id_instr(id_instr[0]), .i_id_vld(id_vld[0]),
        .i_ex_pc_sel(ex_pc_sel[0]), .i_hold(hold[0]), .o_pc_en(pc_en[0]),
        .o_ifid_en(ifid_en[0]), .o_ifid_flush(ifid_flush[0]), .o_idex_flush(idex_flush[0]),
        .o_stall_cnt(stall_cnt[0]), .o_flush_cnt(flush_cnt[0])
    );

    hazard_ctrl #(.WB_BYPASS(0)) dut_nb (
        .i_clk(clk), .i_reset(rst_n), .i_id_instr(id_instr[1]), .i_id_vld(id_vld[1]),
        .i_ex_pc_sel(ex_pc_sel[1]), .i_hold(hold[1]), .o_pc_en(pc_en[1]),
        .o_ifid_en(ifid_en[1]), .o_ifid_flush(ifid_flush[1]), .o_idex_flush(idex_flush[1]),
        .o_stall_cnt(stall_cnt[1]), .o_flush_cnt(flush_cnt[1])
    );

    typedef struct packed {
        logic [3:0]  ctl;   // {pc_en, ifid_en, ifid_flush, idex_flush}
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a register is unreadable until the producer's issue
    // tick plus the depth of the hazard window has passed.
    int          busy [2][32];
    int          tick [2];
    logic [31:0] m_sc [2];
    logic [31:0] m_fc [2];
    logic [31:0] cur_instr [2];
    logic        cur_vld [2];
    logic        drv_sel [2];
    logic        drv_hold [2];
    logic [32:0] prog0[$];
    logic [32:0] prog1[$];
    bit          rnd_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("lane0 ctl", {28'd0, pc_en[0], ifid_en[0], ifid_flush[0], idex_flush[0]}, {28'd0, e.ctl});
            chk("lane0 cnt", stall_cnt[0] ^ {flush_cnt[0][15:0], flush_cnt[0][31:16]},
                e.sc ^ {e.fc[15:0], e.fc[31:16]});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("lane1 ctl", {28'd0, pc_en[1], ifid_en[1], ifid_flush[1], idex_flush[1]}, {28'd0, e.ctl});
            chk("lane1 cnt", stall_cnt[1] ^ {flush_cnt[1][15:0], flush_cnt[1][31:16]},
                e.sc ^ {e.fc[15:0], e.fc[31:16]});
        end
    end

    function automatic void ref_decode(input logic [6:0] op, output bit u1, output bit u2, output bit w);
        u1 = (op == OP_ALU) || (op == OP_ALUI) || (op == OP_LOAD) || (op == OP_JALR) ||
             (op == OP_STORE) || (op == OP_BRANCH);
        u2 = (op == OP_ALU) || (op == OP_STORE) || (op == OP_BRANCH);
        w  = (op == OP_ALU) || (op == OP_ALUI) || (op == OP_LOAD) || (op == OP_JALR) ||
             (op == OP_JAL) || (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic model_clear(input int l);
        for (int r = 0; r < 32; r++) busy[l][r] = -1;
        tick[l] = 0;
        m_sc[l] = 32'd0;
        m_fc[l] = 32'd0;
    endtask

    task automatic fetch(input int l);
        logic [32:0] p;
        logic [6:0]  ops [11];
        ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ALUI, OP_ALU,
                OP_LUI, OP_AUIPC, 7'b1111111, 7'b0001111};
        if (l == 0 && prog0.size() > 0) p = prog0.pop_front();
        else if (l == 1 && prog1.size() > 0) p = prog1.pop_front();
        else if (rnd_mode) begin
            p[31:0] = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
            p[32] = ($urandom_range(0, 9) != 0);
        end else p = 33'd0;
        cur_vld[l]   = p[32];
        cur_instr[l] = p[31:0];
    endtask

    // One clock: drive inputs, predict outputs, advance the model past the edge.
    task automatic step();
        int   mode [2];   // 0 hold, 1 flush, 2 stall, 3 normal
        bit   u1, u2, w, haz;
        logic [4:0] rs1, rs2, rd;
        exp_t e;
        for (int l = 0; l < 2; l++) begin
            id_instr[l]  = cur_instr[l];
            id_vld[l]    = cur_vld[l];
            ex_pc_sel[l] = drv_sel[l];
            hold[l]      = drv_hold[l];
            if (!rst_n) model_clear(l);
            ref_decode(cur_instr[l][6:0], u1, u2, w);
            rs1 = cur_instr[l][19:15];
            rs2 = cur_instr[l][24:20];
            haz = cur_vld[l] && ((u1 && rs1 != 0 && tick[l] <= busy[l][rs1]) ||
                                 (u2 && rs2 != 0 && tick[l] <= busy[l][rs2]));
            if (drv_hold[l])     begin mode[l] = 0; e.ctl = 4'b0000; end
            else if (drv_sel[l]) begin mode[l] = 1; e.ctl = 4'b1111; end
            else if (haz)        begin mode[l] = 2; e.ctl = 4'b0001; end
            else                 begin mode[l] = 3; e.ctl = 4'b1100; end
            e.sc = m_sc[l];
            e.fc = m_fc[l];
            if (l == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            ref_decode(cur_instr[l][6:0], u1, u2, w);
            rd = cur_instr[l][11:7];
            if (!rst_n) begin
                cur_vld[l] = 1'b0;
                cur_instr[l] = 32'd0;
            end else if (mode[l] != 0) begin
                if (mode[l] == 3 && cur_vld[l] && w && rd != 0)
                    busy[l][rd] = tick[l] + ((l == 0) ? 2 : 3);
                if (mode[l] == 2 && m_sc[l] != 32'hFFFF_FFFF) m_sc[l] = m_sc[l] + 1;
                if (mode[l] == 1 && m_fc[l] != 32'hFFFF_FFFF) m_fc[l] = m_fc[l] + 1;
                tick[l]++;
                if (mode[l] == 1) begin
                    cur_vld[l] = 1'b0;
                    cur_instr[l] = 32'd0;
                end else if (mode[l] == 3) fetch(l);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        prog0.delete();
        prog1.delete();
        for (int l = 0; l < 2; l++) begin
            drv_sel[l] = 1'b0;
            drv_hold[l] = 1'b0;
            cur_vld[l] = 1'b0;
            cur_instr[l] = 32'd0;
        end
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] a);
        prog0.push_back({1'b1, a});
        prog1.push_back({1'b1, a});
    endtask

    task automatic set_hold(input logic v);
        drv_hold[0] = v;
        drv_hold[1] = v;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            model_clear(l);
            drv_sel[l] = 1'b0; drv_hold[l] = 1'b0;
            cur_vld[l] = 1'b0; cur_instr[l] = 32'd0;
            id_instr[l] = 32'd0; id_vld[l] = 1'b0; ex_pc_sel[l] = 1'b0; hold[l] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("reset pc_en", {31'd0, pc_en[0]}, 32'd1);
        chk("reset stall_cnt", stall_cnt[1], 32'd0);

        // addi x5,x0,1 ; add x6,x5,x5
        reset_pulse();
        load(mk(OP_ALUI, 5, 0, 1));
        load(mk(OP_ALU, 6, 5, 5));
        run(8);
        chk("raw stalls bypass", stall_cnt[0], 32'd2);
        chk("raw stalls no-bypass", stall_cnt[1], 32'd3);

        // x0 destination never hazards
        reset_pulse();
        load(mk(OP_ALUI, 0, 0, 1));
        load(mk(OP_ALU, 6, 0, 0));
        run(6);
        chk("x0 no stall", stall_cnt[0], 32'd0);
        chk("x0 no stall nb", stall_cnt[1], 32'd0);

        // lui x7,1 ; lui x7,2
        reset_pulse();
        load({20'd1, 5'd7, OP_LUI});
        load({20'd2, 5'd7, OP_LUI});
        run(6);
        chk("lui no stall", stall_cnt[1], 32'd0);

        // lw x5,0(x1) ; sw x5,4(x2)
        reset_pulse();
        load(mk(OP_LOAD, 5, 1, 0));
        load(mk(OP_STORE, 4, 2, 5));
        run(8);
        chk("store rs2 stalls", stall_cnt[0], 32'd2);
        chk("store rs2 stalls nb", stall_cnt[1], 32'd3);

        // Taken branch concurrent with a hazard in ID
        reset_pulse();
        load(mk(OP_ALUI, 5, 0, 1));
        load(mk(OP_ALU, 6, 5, 5));
        run(2);
        drv_sel[0] = 1'b1; drv_sel[1] = 1'b1;
        step();
        drv_sel[0] = 1'b0; drv_sel[1] = 1'b0;
        chk("flush count", flush_cnt[0], 32'd1);
        chk("flush no stall", stall_cnt[0], 32'd0);
        run(4);
        chk("flush no stall nb", stall_cnt[1], 32'd0);

        // Hold in the middle of a stall
        reset_pulse();
        load(mk(OP_ALUI, 5, 0, 1));
        load(mk(OP_ALU, 6, 5, 5));
        run(3);
        set_hold(1'b1);
        run(3);
        chk("hold frozen cnt", stall_cnt[0], 32'd1);
        chk("hold frozen cnt nb", stall_cnt[1], 32'd1);
        set_hold(1'b0);
        run(6);
        chk("hold resume bypass", stall_cnt[0], 32'd2);
        chk("hold resume nb", stall_cnt[1], 32'd3);

        // Reset asserted mid-stall acts without a clock edge
        reset_pulse();
        load(mk(OP_ALUI, 5, 0, 1));
        load(mk(OP_ALU, 6, 5, 5));
        run(3);
        rst_n = 1'b0;
        #1;
        chk("async reset pc_en", {31'd0, pc_en[0]}, 32'd1);
        chk("async reset pc_en nb", {31'd0, pc_en[1]}, 32'd1);
        chk("async reset cnt", stall_cnt[0], 32'd0);
        reset_pulse();
        load(mk(OP_ALU, 6, 5, 5));
        run(5);
        chk("post reset no stall", stall_cnt[1], 32'd0);

        // Randomized traffic
        reset_pulse();
        rnd_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < 2; l++) begin
                drv_sel[l]  = ($urandom_range(0, 9) == 0);
                drv_hold[l] = ($urandom_range(0, 9) == 0);
            end
            step();
        end
        rnd_mode = 0;
        set_hold(1'b0);
        drv_sel[0] = 1'b0; drv_sel[1] = 1'b0;
        run(2);

        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
